// File: rtl/forw_ctrl.sv
// Operand-forwarding control for the execute stage.
// Tracks destination-register tags through the EX, MEM, WB and POST stages. Produces the select
// codes for the operand-A and operand-B forw_mux instances. Raises a one-cycle load-use stall.
// Optional build macro FORW_CTRL_STATS_EN adds saturating stall and forward event counters.

module forw_ctrl #(
  parameter int unsigned REGBITS = 5,
  parameter int unsigned SELBITS = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_dec_valid,
  input  logic [REGBITS-1:0] i_dec_rs,
  input  logic [REGBITS-1:0] i_dec_rt,
  input  logic [REGBITS-1:0] i_dec_rd,
  input  logic               i_dec_regwrite,
  input  logic               i_dec_memread,
  input  logic               i_flush,
  output logic [SELBITS-1:0] o_sel_a,
  output logic [SELBITS-1:0] o_sel_b,
  output logic               o_stall
`ifdef FORW_CTRL_STATS_EN
  ,
  output logic [31:0]        o_stall_cnt,
  output logic [31:0]        o_fwd_cnt
`endif
);

  // Select codes, in the input order of forw_mux.
  localparam logic [SELBITS-1:0] SelRegbnk = SELBITS'(0);
  localparam logic [SELBITS-1:0] SelAlustg = SELBITS'(1);
  localparam logic [SELBITS-1:0] SelMemstg = SELBITS'(2);
  localparam logic [SELBITS-1:0] SelWbstg  = SELBITS'(3);

  localparam logic [REGBITS-1:0] RegZero = '0;

  // EX stage tag
  logic [REGBITS-1:0] ex_rs_q, ex_rs_d;
  logic [REGBITS-1:0] ex_rt_q, ex_rt_d;
  logic [REGBITS-1:0] ex_rd_q, ex_rd_d;
  logic               ex_regwrite_q, ex_regwrite_d;
  logic               ex_memread_q, ex_memread_d;
  logic               ex_valid_q, ex_valid_d;

  // MEM stage tag
  logic [REGBITS-1:0] mem_rd_q, mem_rd_d;
  logic               mem_regwrite_q, mem_regwrite_d;
  logic               mem_memread_q, mem_memread_d;
  logic               mem_valid_q, mem_valid_d;

  // WB stage tag
  logic [REGBITS-1:0] wb_rd_q, wb_rd_d;
  logic               wb_regwrite_q, wb_regwrite_d;
  logic               wb_valid_q, wb_valid_d;

  // POST stage tag: the instruction that has just written the register file
  logic [REGBITS-1:0] post_rd_q, post_rd_d;
  logic               post_regwrite_q, post_regwrite_d;
  logic               post_valid_q, post_valid_d;

  logic stall;
  logic bubble;
  logic [SELBITS-1:0] sel_a;
  logic [SELBITS-1:0] sel_b;

  // A stage supplies a forward only for a live, writing instruction to a nonzero register.
  function automatic logic stage_hit(input logic               valid,
                                     input logic               regwrite,
                                     input logic [REGBITS-1:0] rd,
                                     input logic [REGBITS-1:0] src);
    return valid && regwrite && (rd == src) && (src != RegZero);
  endfunction

  // Youngest producer wins: MEM, then WB, then POST, else the register bank.
  function automatic logic [SELBITS-1:0] fwd_sel(input logic [REGBITS-1:0] src,
                                                 input logic               m_hit,
                                                 input logic               w_hit,
                                                 input logic               p_hit);
    logic [SELBITS-1:0] sel;
    sel = SelRegbnk;
    if (src != RegZero) begin
      if (m_hit) begin
        sel = SelAlustg;
      end else if (w_hit) begin
        sel = SelMemstg;
      end else if (p_hit) begin
        sel = SelWbstg;
      end
    end
    return sel;
  endfunction

  // Load-use hazard detection; a flushed decode instruction never stalls.
  always_comb begin
    stall = i_dec_valid && !i_flush && ex_valid_q && ex_memread_q && (ex_rd_q != RegZero) &&
            ((ex_rd_q == i_dec_rs) || (ex_rd_q == i_dec_rt));
    bubble = i_flush || stall || !i_dec_valid;
  end

  // Forwarding selects from the registered tags of the instruction currently in EX.
  always_comb begin
    sel_a = fwd_sel(ex_rs_q,
                    stage_hit(mem_valid_q, mem_regwrite_q, mem_rd_q, ex_rs_q),
                    stage_hit(wb_valid_q, wb_regwrite_q, wb_rd_q, ex_rs_q),
                    stage_hit(post_valid_q, post_regwrite_q, post_rd_q, ex_rs_q));
    sel_b = fwd_sel(ex_rt_q,
                    stage_hit(mem_valid_q, mem_regwrite_q, mem_rd_q, ex_rt_q),
                    stage_hit(wb_valid_q, wb_regwrite_q, wb_rd_q, ex_rt_q),
                    stage_hit(post_valid_q, post_regwrite_q, post_rd_q, ex_rt_q));
  end

  assign o_sel_a = sel_a;
  assign o_sel_b = sel_b;
  assign o_stall = stall;

  // Next-state of the tag pipeline: EX takes decode or a bubble, older stages always shift.
  always_comb begin
    ex_rs_d       = RegZero;
    ex_rt_d       = RegZero;
    ex_rd_d       = RegZero;
    ex_regwrite_d = 1'b0;
    ex_memread_d  = 1'b0;
    ex_valid_d    = 1'b0;
    if (!bubble) begin
      ex_rs_d       = i_dec_rs;
      ex_rt_d       = i_dec_rt;
      ex_rd_d       = i_dec_rd;
      ex_regwrite_d = i_dec_regwrite;
      ex_memread_d  = i_dec_memread;
      ex_valid_d    = 1'b1;
    end

    mem_rd_d        = ex_rd_q;
    mem_regwrite_d  = ex_regwrite_q;
    mem_memread_d   = ex_memread_q;
    mem_valid_d     = ex_valid_q;

    wb_rd_d         = mem_rd_q;
    wb_regwrite_d   = mem_regwrite_q;
    wb_valid_d      = mem_valid_q;

    post_rd_d       = wb_rd_q;
    post_regwrite_d = wb_regwrite_q;
    post_valid_d    = wb_valid_q;
  end

  // Tag pipeline registers with synchronous active-low clear.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      ex_rs_q         <= RegZero;
      ex_rt_q         <= RegZero;
      ex_rd_q         <= RegZero;
      ex_regwrite_q   <= 1'b0;
      ex_memread_q    <= 1'b0;
      ex_valid_q      <= 1'b0;
      mem_rd_q        <= RegZero;
      mem_regwrite_q  <= 1'b0;
      mem_memread_q   <= 1'b0;
      mem_valid_q     <= 1'b0;
      wb_rd_q         <= RegZero;
      wb_regwrite_q   <= 1'b0;
      wb_valid_q      <= 1'b0;
      post_rd_q       <= RegZero;
      post_regwrite_q <= 1'b0;
      post_valid_q    <= 1'b0;
    end else begin
      ex_rs_q         <= ex_rs_d;
      ex_rt_q         <= ex_rt_d;
      ex_rd_q         <= ex_rd_d;
      ex_regwrite_q   <= ex_regwrite_d;
      ex_memread_q    <= ex_memread_d;
      ex_valid_q      <= ex_valid_d;
      mem_rd_q        <= mem_rd_d;
      mem_regwrite_q  <= mem_regwrite_d;
      mem_memread_q   <= mem_memread_d;
      mem_valid_q     <= mem_valid_d;
      wb_rd_q         <= wb_rd_d;
      wb_regwrite_q   <= wb_regwrite_d;
      wb_valid_q      <= wb_valid_d;
      post_rd_q       <= post_rd_d;
      post_regwrite_q <= post_regwrite_d;
      post_valid_q    <= post_valid_d;
    end
  end

  // A load in MEM can never feed the instruction behind it directly: the stall put a bubble
  // between them, so its data is only ever picked up from the WB tag.
  load_in_mem_never_consumed : assert property (@(posedge i_clk) disable iff (!i_reset)
    !(mem_valid_q && mem_memread_q && ex_valid_q && (mem_rd_q != RegZero) &&
      ((mem_rd_q == ex_rs_q) || (mem_rd_q == ex_rt_q))));

`ifdef FORW_CTRL_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (ex_valid_q && ((sel_a != SelRegbnk) || (sel_b != SelRegbnk)) &&
        (fwd_cnt_q != 32'hFFFF_FFFF)) begin
      fwd_cnt_d = fwd_cnt_q + 32'd1;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      stall_cnt_q <= 32'd0;
      fwd_cnt_q   <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_fwd_cnt   = fwd_cnt_q;
`else
  // Statistics disabled: no counter state and no extra ports.
`endif

endmodule

// File: tb/tb_forw_ctrl.sv
// Scoreboard bench for forw_ctrl: the driver applies one decode vector per cycle and queues the
// hand-computed selects/stall for that cycle; a negedge monitor pops and compares.

module tb_forw_ctrl;

  logic       i_clk;
  logic       i_reset;
  logic       i_dec_valid;
  logic [4:0] i_dec_rs;
  logic [4:0] i_dec_rt;
  logic [4:0] i_dec_rd;
  logic       i_dec_regwrite;
  logic       i_dec_memread;
  logic       i_flush;
  logic [1:0] o_sel_a;
  logic [1:0] o_sel_b;
  logic       o_stall;
`ifdef FORW_CTRL_STATS_EN
  logic [31:0] o_stall_cnt;
  logic [31:0] o_fwd_cnt;
`endif

  forw_ctrl #(
    .REGBITS(5),
    .SELBITS(2)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_dec_valid    (i_dec_valid),
    .i_dec_rs       (i_dec_rs),
    .i_dec_rt       (i_dec_rt),
    .i_dec_rd       (i_dec_rd),
    .i_dec_regwrite (i_dec_regwrite),
    .i_dec_memread  (i_dec_memread),
    .i_flush        (i_flush),
    .o_sel_a        (o_sel_a),
    .o_sel_b        (o_sel_b),
    .o_stall        (o_stall)
`ifdef FORW_CTRL_STATS_EN
    ,
    .o_stall_cnt    (o_stall_cnt),
    .o_fwd_cnt      (o_fwd_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    int          cyc;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic        stall;
    logic        chk_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] fwd_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Counter expectation attached to the next queued entry.
  logic        nxt_chk_cnt = 1'b0;
  logic [31:0] nxt_stall_cnt = 32'd0;
  logic [31:0] nxt_fwd_cnt = 32'd0;

  task automatic step(input logic rst, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic rw, input logic mr, input logic fl,
                      input logic [1:0] ea, input logic [1:0] eb, input logic es);
    exp_t e;
    i_reset        = rst;
    i_dec_valid    = v;
    i_dec_rs       = rs;
    i_dec_rt       = rt;
    i_dec_rd       = rd;
    i_dec_regwrite = rw;
    i_dec_memread  = mr;
    i_flush        = fl;
    cyc++;
    e.cyc       = cyc;
    e.sel_a     = ea;
    e.sel_b     = eb;
    e.stall     = es;
    e.chk_cnt   = nxt_chk_cnt;
    e.stall_cnt = nxt_stall_cnt;
    e.fwd_cnt   = nxt_fwd_cnt;
    exp_q.push_back(e);
    nxt_chk_cnt = 1'b0;
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: outputs are valid every cycle, compared mid-cycle.
  always @(negedge i_clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (o_sel_a !== e.sel_a) begin
        failures++;
        $display("FAIL sel_a cyc=%0d actual=%b required=%b", e.cyc, o_sel_a, e.sel_a);
      end
      checks++;
      if (o_sel_b !== e.sel_b) begin
        failures++;
        $display("FAIL sel_b cyc=%0d actual=%b required=%b", e.cyc, o_sel_b, e.sel_b);
      end
      checks++;
      if (o_stall !== e.stall) begin
        failures++;
        $display("FAIL stall cyc=%0d actual=%b required=%b", e.cyc, o_stall, e.stall);
      end
`ifdef FORW_CTRL_STATS_EN
      if (e.chk_cnt) begin
        checks++;
        if (o_stall_cnt !== e.stall_cnt) begin
          failures++;
          $display("FAIL stall_cnt cyc=%0d actual=%0d required=%0d", e.cyc, o_stall_cnt,
                   e.stall_cnt);
        end
        checks++;
        if (o_fwd_cnt !== e.fwd_cnt) begin
          failures++;
          $display("FAIL fwd_cnt cyc=%0d actual=%0d required=%0d", e.cyc, o_fwd_cnt, e.fwd_cnt);
        end
      end
`endif
    end
  end

  initial begin
    i_reset        = 1'b0;
    i_dec_valid    = 1'b0;
    i_dec_rs       = '0;
    i_dec_rt       = '0;
    i_dec_rd       = '0;
    i_dec_regwrite = 1'b0;
    i_dec_memread  = 1'b0;
    i_flush        = 1'b0;
    @(posedge i_clk);
    #1;

    // Reset held with random decode inputs: tags stay cleared.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
           1'($urandom), 1'b0, 2'd0, 2'd0, 1'b0);
    end

    //    rst   v     rs     rt     rd     rw    mr    fl      a     b     stall
    // Back-to-back ALU forwarding at distances 1, 2, 3 (I2 writes r3).
    step(1'b1, 1'b1, 5'd5,  5'd6,  5'd8,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    step(1'b1, 1'b1, 5'd1,  5'd2,  5'd3,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    step(1'b1, 1'b1, 5'd3,  5'd4,  5'd11, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    step(1'b1, 1'b1, 5'd3,  5'd22, 5'd23, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0);
    step(1'b1, 1'b1, 5'd3,  5'd24, 5'd25, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0);
    // Priority: r7 written at distances 1 and 2, then read on both operands.
    step(1'b1, 1'b1, 5'd26, 5'd27, 5'd7,  1'b1, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0);
    step(1'b1, 1'b1, 5'd26, 5'd27, 5'd7,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    step(1'b1, 1'b1, 5'd7,  5'd7,  5'd28, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    // r0 written and read; r30 "written" with regwrite=0 and read.
    step(1'b1, 1'b1, 5'd1,  5'd2,  5'd0,  1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 1'b0);
    step(1'b1, 1'b1, 5'd0,  5'd0,  5'd29, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    step(1'b1, 1'b1, 5'd12, 5'd13, 5'd30, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    step(1'b1, 1'b1, 5'd30, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    // Load-use on rs: lw r9; dependent stalls one cycle, then forwards from WB.
    step(1'b1, 1'b1, 5'd1,  5'd0,  5'd9,  1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    step(1'b1, 1'b1, 5'd9,  5'd4,  5'd10, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
    step(1'b1, 1'b1, 5'd9,  5'd4,  5'd10, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    // lw r9 followed by an instruction reading only r10: no stall.
    step(1'b1, 1'b1, 5'd0,  5'd0,  5'd9,  1'b1, 1'b1, 1'b0, 2'd2, 2'd0, 1'b0);
    step(1'b1, 1'b1, 5'd10, 5'd10, 5'd12, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    // Flush beats stall: lw r14 in EX, matching decode flushed.
    step(1'b1, 1'b1, 5'd0,  5'd0,  5'd14, 1'b1, 1'b1, 1'b0, 2'd2, 2'd2, 1'b0);
    step(1'b1, 1'b1, 5'd14, 5'd0,  5'd15, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
    step(1'b1, 1'b0, 5'd14, 5'd0,  5'd15, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    // Load-use on rt.
    step(1'b1, 1'b1, 5'd0,  5'd0,  5'd17, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    step(1'b1, 1'b1, 5'd0,  5'd17, 5'd18, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
    step(1'b1, 1'b1, 5'd0,  5'd17, 5'd18, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    step(1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0);
    // Invalid decode behind a matching load: no stall.
    step(1'b1, 1'b1, 5'd0,  5'd0,  5'd19, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    step(1'b1, 1'b0, 5'd19, 5'd19, 5'd20, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    // Writer of r5, reset mid-run, then a reader of r5 finds no producer.
    nxt_chk_cnt = 1'b1; nxt_stall_cnt = 32'd2; nxt_fwd_cnt = 32'd7;
    step(1'b1, 1'b1, 5'd0,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    step(1'b0, 1'b1, 5'd5,  5'd5,  5'd6,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    nxt_chk_cnt = 1'b1; nxt_stall_cnt = 32'd0; nxt_fwd_cnt = 32'd0;
    step(1'b1, 1'b1, 5'd5,  5'd5,  5'd6,  1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    nxt_chk_cnt = 1'b1; nxt_stall_cnt = 32'd0; nxt_fwd_cnt = 32'd0;
    step(1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);

    @(negedge i_clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
